dot_round_ctrl: RTL and testbench

DOT_ROUND_CTRL -- requirements
Module: dot_round_ctrl

---
 rtl/dot_round_pkg.sv | 34 +++
 rtl/popcount32.sv | 22 ++
 rtl/dot_round_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dot_round_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_round_pkg.sv
// ============================================================================
// Module : dot_round_pkg
// Brief  : Shared state encodings and score values for the dot round control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dot_round_pkg;

    localparam logic [2:0] c_ST_IDLE       = 3'd0;
    localparam logic [2:0] c_ST_CLEAR      = 3'd1;
    localparam logic [2:0] c_ST_PLAY       = 3'd2;
    localparam logic [2:0] c_ST_DYING      = 3'd3;
    localparam logic [2:0] c_ST_LEVEL_DONE = 3'd4;
    localparam logic [2:0] c_ST_PAUSE      = 3'd5;
    localparam logic [2:0] c_ST_OVER       = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE       = c_ST_IDLE,
        ST_CLEAR      = c_ST_CLEAR,
        ST_PLAY       = c_ST_PLAY,
        ST_DYING      = c_ST_DYING,
        ST_LEVEL_DONE = c_ST_LEVEL_DONE,
        ST_PAUSE      = c_ST_PAUSE,
        ST_OVER       = c_ST_OVER
    } state_e;

    localparam logic [15:0] c_PTS_DOT   = 16'd10;
    localparam logic [15:0] c_PTS_POWER = 16'd50;
    localparam logic [15:0] c_PTS_GHOST = 16'd200;

endpackage

`default_nettype wire

// File: rtl/popcount32.sv
// ============================================================================
// Module : popcount32
// Brief  : Combinational count of set bits in a 32-bit word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module popcount32 (
    input  logic [31:0] i_data,
    output logic [5:0]  o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < 32; i++) begin
            o_count = o_count + 6'(i_data[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dot_round_ctrl.sv
// ============================================================================
// Module : dot_round_ctrl
// Brief  : Round sequencer for a maze game: dot scoring, power mode, lives,
//          levels and inter-round pauses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dot_round_ctrl
    import dot_round_pkg::*;
#(
    parameter int unsigned NUM_DOTS     = 32,
    parameter logic [31:0] POWER_MASK   = 32'h1000_0011,
    parameter int unsigned CLEAR_CYCLES = 4,
    parameter int unsigned PAUSE_FRAMES = 120,
    parameter int unsigned POWER_FRAMES = 360
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                start,
    input  logic                frame_tick,
    input  logic [NUM_DOTS-1:0] eaten,
    input  logic                pac_hit,
    output logic                dot_clear,
    output logic [15:0]         score,
    output logic [5:0]          dots_left,
    output logic [3:0]          level,
    output logic [1:0]          lives,
    output logic                power_active,
    output logic [2:0]          state,
    output logic                game_over
);

    localparam int c_CLR_W   = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int c_PAUSE_W = $clog2(PAUSE_FRAMES + 2);
    localparam int c_PWR_W   = $clog2(POWER_FRAMES + 1);

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [31:0]          w_eaten_pad;
    logic [31:0]          r_eaten_q;
    logic [31:0]          w_new;
    logic [31:0]          w_new_pow;
    logic [5:0]           w_n_new;
    logic [5:0]           w_n_pow;
    logic [5:0]           w_n_eaten;
    logic [5:0]           w_left;
    logic                 r_pac_q;
    logic                 w_ghost;
    logic [17:0]          w_add;
    logic [17:0]          w_sum;
    logic [15:0]          w_score_sat;
    logic [15:0]          r_score;
    logic [5:0]           r_dots_left;
    logic [3:0]           r_level;
    logic [1:0]           r_lives;
    logic                 r_power;
    logic [c_PWR_W-1:0]   r_power_cnt;
    logic [c_CLR_W-1:0]   r_clr_cnt;
    logic [c_PAUSE_W-1:0] r_frame_cnt;
    logic [c_PAUSE_W-1:0] w_pause_cnt;
    logic                 r_after_level;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    always_comb begin
        w_eaten_pad                 = '0;
        w_eaten_pad[NUM_DOTS-1:0]   = eaten;
    end

    assign w_new     = w_eaten_pad & ~r_eaten_q;
    assign w_new_pow = w_new & POWER_MASK;

    popcount32 u_pop_new   (.i_data(w_new),       .o_count(w_n_new));
    popcount32 u_pop_pow   (.i_data(w_new_pow),   .o_count(w_n_pow));
    popcount32 u_pop_eaten (.i_data(w_eaten_pad), .o_count(w_n_eaten));

    assign w_left  = 6'(NUM_DOTS) - w_n_eaten;
    assign w_ghost = r_power & pac_hit & ~r_pac_q;

    assign w_add = 18'(w_n_new - w_n_pow) * 18'(c_PTS_DOT)
                 + 18'(w_n_pow) * 18'(c_PTS_POWER)
                 + (w_ghost ? 18'(c_PTS_GHOST) : 18'd0);
    assign w_sum       = {2'b00, r_score} + w_add;
    assign w_score_sat = (w_sum > 18'h0FFFF) ? 16'hFFFF : w_sum[15:0];

    assign w_pause_cnt = r_frame_cnt + c_PAUSE_W'(frame_tick);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:       if (start) w_next = c_ST_CLEAR;
            c_ST_CLEAR:      if (r_clr_cnt == c_CLR_W'(CLEAR_CYCLES - 1)) w_next = c_ST_PLAY;
            c_ST_PLAY: begin
                // Finishing the level takes priority over a same-clock death.
                if (w_left == 6'd0)          w_next = c_ST_LEVEL_DONE;
                else if (pac_hit && !r_power) w_next = c_ST_DYING;
            end
            c_ST_DYING:      w_next = (r_lives <= 2'd1) ? c_ST_OVER : c_ST_PAUSE;
            c_ST_LEVEL_DONE: w_next = c_ST_PAUSE;
            c_ST_PAUSE: begin
                if (w_pause_cnt >= c_PAUSE_W'(PAUSE_FRAMES))
                    w_next = r_after_level ? c_ST_CLEAR : c_ST_PLAY;
            end
            c_ST_OVER:       if (start) w_next = c_ST_IDLE;
            default:         w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= c_ST_IDLE;
            r_eaten_q     <= '0;
            r_pac_q       <= 1'b0;
            r_score       <= '0;
            r_dots_left   <= 6'(NUM_DOTS);
            r_level       <= '0;
            r_lives       <= '0;
            r_power       <= 1'b0;
            r_power_cnt   <= '0;
            r_clr_cnt     <= '0;
            r_frame_cnt   <= '0;
            r_after_level <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pac_q   <= pac_hit;
            r_eaten_q <= (r_state == c_ST_CLEAR) ? '0 : w_eaten_pad;
            r_clr_cnt <= (r_state == c_ST_CLEAR && w_next == c_ST_CLEAR) ?
                         r_clr_cnt + c_CLR_W'(1) : '0;

            // A tick on the clock that enters PAUSE is its first counted frame.
            if (w_next == c_ST_PAUSE)
                r_frame_cnt <= (r_state == c_ST_PAUSE) ? w_pause_cnt : c_PAUSE_W'(frame_tick);
            else
                r_frame_cnt <= '0;

            if (r_state == c_ST_CLEAR || r_state == c_ST_PLAY)
                r_dots_left <= w_left;

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_score <= '0;
                        r_level <= 4'd1;
                        r_lives <= 2'd3;
                    end
                end
                c_ST_PLAY:  r_score <= w_score_sat;
                c_ST_DYING: begin
                    if (r_lives != 2'd0) r_lives <= r_lives - 2'd1;
                    r_after_level <= 1'b0;
                end
                c_ST_LEVEL_DONE: begin
                    if (r_level != 4'hF) r_level <= r_level + 4'd1;
                    r_after_level <= 1'b1;
                end
                default: ;
            endcase

            if (r_state == c_ST_LEVEL_DONE || (r_state == c_ST_IDLE && start)) begin
                r_power     <= 1'b0;
                r_power_cnt <= '0;
            end else if (r_state == c_ST_PLAY && w_new_pow != 32'd0) begin
                r_power     <= 1'b1;
                r_power_cnt <= c_PWR_W'(POWER_FRAMES);
            end else if (r_power && frame_tick) begin
                r_power_cnt <= r_power_cnt - c_PWR_W'(1);
                if (r_power_cnt <= c_PWR_W'(1)) r_power <= 1'b0;
            end
        end
    end

    assign dot_clear    = ~w_rst_n | (r_state == c_ST_CLEAR);
    assign score        = r_score;
    assign dots_left    = r_dots_left;
    assign level        = r_level;
    assign lives        = r_lives;
    assign power_active = r_power;
    assign state        = r_state;
    assign game_over    = (r_state == c_ST_OVER);

endmodule

`default_nettype wire

// File: tb/tb_dot_round_ctrl.sv
// ============================================================================
// Module : tb_dot_round_ctrl
// Brief  : Self-checking bench for dot_round_ctrl with a score/dot model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dot_round_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_PLAY = 3'd2, S_DYING = 3'd3;
    localparam logic [2:0] S_LVL  = 3'd4, S_PAUSE = 3'd5, S_OVER = 3'd6;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic        frame_tick = 1'b0;
    logic        pac_hit = 1'b0;
    logic [31:0] eaten = '0;
    logic        dot_clear;
    logic [15:0] score;
    logic [5:0]  dots_left;
    logic [3:0]  level;
    logic [1:0]  lives;
    logic        power_active;
    logic [2:0]  state;
    logic        game_over;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_score  = 0;
    logic [31:0] m_field  = '0;
    logic [31:0] pmask    = 32'h1000_0011;

    dot_round_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .frame_tick(frame_tick),
        .eaten(eaten), .pac_hit(pac_hit), .dot_clear(dot_clear), .score(score),
        .dots_left(dots_left), .level(level), .lives(lives),
        .power_active(power_active), .state(state), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    task automatic clk1();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            clk1();
            frame_tick = 1'b0;
            clk1();
        end
    endtask

    task automatic wait_for(input logic [2:0] s, input int budget);
        for (int k = 0; k < budget && state !== s; k++) clk1();
    endtask

    function automatic int pts(input logic [31:0] nb);
        int s = 0;
        for (int i = 0; i < 32; i++) if (nb[i]) s += pmask[i] ? 50 : 10;
        return s;
    endfunction

    function automatic int pick_normal();
        int idx;
        do idx = int'($urandom_range(31, 0)); while (m_field[idx] || pmask[idx]);
        return idx;
    endfunction

    function automatic int left_m();
        return 32 - $countones(m_field);
    endfunction

    task automatic eat(input logic [31:0] bits, input logic with_pac);
        logic [31:0] nb;
        nb      = bits & ~m_field;
        m_field = m_field | bits;
        m_score += pts(nb);
        eaten   = m_field;
        pac_hit = with_pac;
        clk1();
        pac_hit = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) clk1();
        n_checks++; if (state !== S_IDLE) $display("FAIL rst_state: got %0d want 0", state); else n_pass++;
        n_checks++; if (dot_clear !== 1'b1) $display("FAIL rst_dot_clear: got %b want 1", dot_clear); else n_pass++;
        n_checks++; if (score !== 16'd0) $display("FAIL rst_score: got %0d want 0", score); else n_pass++;
        n_checks++; if (dots_left !== 6'd32) $display("FAIL rst_dots_left: got %0d want 32", dots_left); else n_pass++;
        n_checks++; if (level !== 4'd0 || lives !== 2'd0) $display("FAIL rst_level_lives: got %0d/%0d want 0/0", level, lives); else n_pass++;
        n_checks++; if (power_active !== 1'b0 || game_over !== 1'b0) $display("FAIL rst_flags: got %b%b want 00", power_active, game_over); else n_pass++;
        Reset_n = 1'b1;
        repeat (4) clk1();
        n_checks++; if (dot_clear !== 1'b0 || state !== S_IDLE) $display("FAIL idle_dot_clear: got %b st %0d want 0 st 0", dot_clear, state); else n_pass++;
    endtask

    task automatic test_start();
        int n_clr = 0;
        start = 1'b1; frame_tick = 1'b1;
        clk1();
        start = 1'b0; frame_tick = 1'b0;
        for (int k = 0; k < 20 && state === S_CLEAR; k++) begin
            if (dot_clear === 1'b1) n_clr++;
            clk1();
        end
        n_checks++; if (n_clr != 4) $display("FAIL clear_len: got %0d want 4", n_clr); else n_pass++;
        n_checks++; if (state !== S_PLAY) $display("FAIL play_entry: got %0d want 2", state); else n_pass++;
        n_checks++; if (dots_left !== 6'd32 || lives !== 2'd3 || level !== 4'd1 || score !== 16'd0)
            $display("FAIL play_init: got dl %0d lv %0d lvl %0d sc %0d want 32 3 1 0", dots_left, lives, level, score); else n_pass++;
        m_score = 0; m_field = '0;
    endtask

    task automatic test_scoring();
        logic [31:0] b;
        eat(32'h0000_0006, 1'b0);
        n_checks++; if (score !== 16'd20 || dots_left !== 6'd30) $display("FAIL score_pair: got %0d dl %0d want 20 dl 30", score, dots_left); else n_pass++;
        eat(32'h0000_0001, 1'b0);
        n_checks++; if (score !== 16'd70 || dots_left !== 6'd29) $display("FAIL score_power: got %0d dl %0d want 70 dl 29", score, dots_left); else n_pass++;
        n_checks++; if (power_active !== 1'b1) $display("FAIL power_set: got %b want 1", power_active); else n_pass++;
        for (int r = 0; r < 5; r++) begin
            b = '0;
            for (int j = 0; j < int'($urandom_range(3, 1)); j++) b[pick_normal()] = 1'b1;
            eat(b, 1'b0);
            n_checks++; if (score !== 16'(m_score)) $display("FAIL score_rand%0d: got %0d want %0d", r, score, m_score); else n_pass++;
            n_checks++; if (dots_left !== 6'(left_m())) $display("FAIL dl_rand%0d: got %0d want %0d", r, dots_left, left_m()); else n_pass++;
        end
    endtask

    task automatic test_power();
        eat(32'h0000_0010, 1'b0);
        ticks(100);
        pac_hit = 1'b1;
        repeat (3) clk1();
        pac_hit = 1'b0;
        clk1();
        m_score += 200;
        n_checks++; if (score !== 16'(m_score)) $display("FAIL ghost_bonus: got %0d want %0d", score, m_score); else n_pass++;
        n_checks++; if (state !== S_PLAY) $display("FAIL ghost_state: got %0d want 2", state); else n_pass++;
        ticks(259);
        n_checks++; if (power_active !== 1'b1) $display("FAIL power_359: got %b want 1", power_active); else n_pass++;
        ticks(1);
        n_checks++; if (power_active !== 1'b0) $display("FAIL power_360: got %b want 0", power_active); else n_pass++;
    endtask

    task automatic test_death();
        logic [15:0] sc;
        logic [5:0]  dl;
        pac_hit = 1'b1; clk1(); pac_hit = 1'b0;
        n_checks++; if (state !== S_DYING) $display("FAIL dying: got %0d want 3", state); else n_pass++;
        clk1();
        n_checks++; if (lives !== 2'd2 || state !== S_PAUSE) $display("FAIL death1: got lv %0d st %0d want 2 st 5", lives, state); else n_pass++;
        ticks(119);
        n_checks++; if (state !== S_PAUSE) $display("FAIL pause_119: got %0d want 5", state); else n_pass++;
        ticks(1);
        n_checks++; if (state !== S_PLAY) $display("FAIL pause_120: got %0d want 2", state); else n_pass++;
        // Second death: the tick on the PAUSE-entry clock is the first pause frame.
        pac_hit = 1'b1; clk1(); pac_hit = 1'b0;
        frame_tick = 1'b1; clk1(); frame_tick = 1'b0;
        n_checks++; if (lives !== 2'd1 || state !== S_PAUSE) $display("FAIL death2: got lv %0d st %0d want 1 st 5", lives, state); else n_pass++;
        clk1();
        ticks(118);
        n_checks++; if (state !== S_PAUSE) $display("FAIL entry_tick_pre: got %0d want 5", state); else n_pass++;
        ticks(1);
        n_checks++; if (state !== S_PLAY) $display("FAIL entry_tick: got %0d want 2", state); else n_pass++;
        pac_hit = 1'b1; clk1(); pac_hit = 1'b0; clk1();
        n_checks++; if (state !== S_OVER || game_over !== 1'b1 || lives !== 2'd0)
            $display("FAIL over: got st %0d go %b lv %0d want 6 1 0", state, game_over, lives); else n_pass++;
        sc = 16'(m_score); dl = 6'(left_m());
        eaten = m_field | (32'h1 << pick_normal());
        ticks(5);
        n_checks++; if (state !== S_OVER || score !== sc || dots_left !== dl)
            $display("FAIL over_hold: got st %0d sc %0d dl %0d want 6 %0d %0d", state, score, dots_left, sc, dl); else n_pass++;
    endtask

    task automatic test_level_done();
        logic [31:0] rest, a;
        start = 1'b1; clk1(); start = 1'b0;
        n_checks++; if (state !== S_IDLE || game_over !== 1'b0) $display("FAIL over_to_idle: got %0d want 0", state); else n_pass++;
        eaten = '0; m_field = '0; m_score = 0;
        start = 1'b1; clk1(); start = 1'b0;
        wait_for(S_PLAY, 12);
        n_checks++; if (state !== S_PLAY || lives !== 2'd3 || score !== 16'd0)
            $display("FAIL restart: got st %0d lv %0d sc %0d want 2 3 0", state, lives, score); else n_pass++;
        rest = 32'hFFFF_FF7F;
        a = rest & $urandom();
        eat(a, 1'b0);
        eat(rest, 1'b0);
        n_checks++; if (score !== 16'(m_score) || dots_left !== 6'd1)
            $display("FAIL bulk_eat: got %0d dl %0d want %0d dl 1", score, dots_left, m_score); else n_pass++;
        ticks(360);
        n_checks++; if (power_active !== 1'b0) $display("FAIL power_expired: got %b want 0", power_active); else n_pass++;
        eat(32'h0000_0080, 1'b1);
        n_checks++; if (state !== S_LVL || lives !== 2'd3 || score !== 16'(m_score))
            $display("FAIL level_wins: got st %0d lv %0d sc %0d want 4 3 %0d", state, lives, score, m_score); else n_pass++;
        clk1();
        n_checks++; if (level !== 4'd2 || state !== S_PAUSE || dots_left !== 6'd0)
            $display("FAIL level_up: got lvl %0d st %0d dl %0d want 2 5 0", level, state, dots_left); else n_pass++;
        ticks(120);
        n_checks++; if (state !== S_CLEAR || dot_clear !== 1'b1) $display("FAIL pause_to_clear: got st %0d dc %b want 1 1", state, dot_clear); else n_pass++;
        eaten = '0; m_field = '0;
        wait_for(S_PLAY, 12);
        n_checks++; if (dots_left !== 6'd32 || state !== S_PLAY) $display("FAIL new_level: got dl %0d st %0d want 32 2", dots_left, state); else n_pass++;
        pac_hit = 1'b1; clk1(); pac_hit = 1'b0; clk1();
        n_checks++; if (state !== S_PAUSE || lives !== 2'd2) $display("FAIL lvl2_death: got st %0d lv %0d want 5 2", state, lives); else n_pass++;
    endtask

    task automatic test_reset_mid_pause();
        eat(32'h0000_0001 | (32'h1 << pick_normal()), 1'b0);
        ticks(10);
        #2;
        Reset_n = 1'b0;
        #1;
        n_checks++; if (state !== S_IDLE || dot_clear !== 1'b1 || score !== 16'd0 || dots_left !== 6'd32)
            $display("FAIL async_rst_a: got st %0d dc %b sc %0d dl %0d want 0 1 0 32", state, dot_clear, score, dots_left); else n_pass++;
        n_checks++; if (level !== 4'd0 || lives !== 2'd0 || power_active !== 1'b0 || game_over !== 1'b0)
            $display("FAIL async_rst_b: got lvl %0d lv %0d pw %b go %b want 0 0 0 0", level, lives, power_active, game_over); else n_pass++;
        repeat (2) clk1();
        Reset_n = 1'b1;
        repeat (4) clk1();
        n_checks++; if (state !== S_IDLE || dot_clear !== 1'b0) $display("FAIL rst_release: got st %0d dc %b want 0 0", state, dot_clear); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] b;
        eaten = '0; m_field = '0; m_score = 0;
        start = 1'b1; clk1(); start = 1'b0;
        wait_for(S_PLAY, 12);
        for (int r = 0; r < 3; r++) begin
            b = '0;
            for (int j = 0; j < int'($urandom_range(4, 1)); j++) b[pick_normal()] = 1'b1;
            eat(b, 1'b0);
            n_checks++; if (score !== 16'(m_score) || dots_left !== 6'(left_m()))
                $display("FAIL fresh_round%0d: got sc %0d dl %0d want %0d %0d", r, score, dots_left, m_score, left_m()); else n_pass++;
        end
        n_checks++; if (power_active !== 1'b0 || level !== 4'd1 || lives !== 2'd3)
            $display("FAIL fresh_state: got pw %b lvl %0d lv %0d want 0 1 3", power_active, level, lives); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_scoring();
        test_power();
        test_death();
        test_level_done();
        test_reset_mid_pause();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
